if_fetch_unit: RTL

- RV32I instruction-fetch stage; drives the 32-bit instruction word consumed by the ID-stage control decoder.
- Owns the PC, runs a single-outstanding request/ack protocol to instruction memory, and holds the IF/ID pipeline register plus a one-entry skid buffer.
- Honours ID back-pressure (stall) and EX redirects (jump/branch), squashing wrong-path instructions.

---
 rtl/rv32_pkg.sv | 21 ++
 rtl/if_fetch_unit_if.sv | 26 ++
 rtl/if_skid_buffer.sv | 54 +++++
 rtl/if_fetch_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 fetch constants, fetch FSM encoding and PC alignment helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32_pkg;

    localparam int INST_W = 32;

    localparam logic [31:0]       DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [INST_W-1:0] DEFAULT_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch stage and imem.
// Latency: ack may come one or more cycles after imem_req rises.
// Backpressure: imem_req and imem_addr are held until imem_ack.
interface if_fetch_unit_if;
    import rv32_pkg::*;

    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_skid_buffer.sv
// One-entry holding slot for a fetched word that ID could not take.
// Latency: pushed entry is readable the cycle after push.
// Backpressure: none internally; flush beats push, push beats pop.
module if_skid_buffer
    import rv32_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [INST_W-1:0] push_inst,
    input  logic [31:0]       push_pc,
    input  logic              pop,
    input  logic              flush,
    output logic              vld,
    output logic [INST_W-1:0] inst,
    output logic [31:0]       pc
);

    logic              vld_q, vld_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [31:0]       pc_q, pc_d;

    always_comb begin
        vld_d  = vld_q;
        inst_d = inst_q;
        pc_d   = pc_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (push) begin
            vld_d  = 1'b1;
            inst_d = push_inst;
            pc_d   = push_pc;
        end else if (pop) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= 1'b0;
            inst_q <= '0;
            pc_q   <= '0;
        end else begin
            vld_q  <= vld_d;
            inst_q <= inst_d;
            pc_q   <= pc_d;
        end
    end

    assign vld  = vld_q;
    assign inst = inst_q;
    assign pc   = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I fetch stage: PC, single-outstanding imem fetch, IF/ID register + 1-entry skid.
// Latency: ack in cycle N is visible on id_* in cycle N+1.
// Backpressure: stall holds IF/ID; a word acked under stall parks in skid and requests pause.
module if_fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0]       RESET_PC = DEFAULT_RESET_PC,
    parameter logic [INST_W-1:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic              clk,
    input  logic              reset,
    if_fetch_unit_if.master   imem,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              id_valid,
    output logic [INST_W-1:0] id_inst,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_pc_plus4,
    output logic              fetch_misalign
);

    fetch_state_e      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       addr_q, addr_d;
    logic              id_valid_q, id_valid_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;
    logic [31:0]       id_pc_q, id_pc_d;
    logic [31:0]       id_pc_plus4_q, id_pc_plus4_d;
    logic              misalign_q, misalign_d;

    logic              skid_vld, skid_push, skid_pop, skid_flush;
    logic [INST_W-1:0] skid_inst;
    logic [31:0]       skid_pc;

    logic ack_live, ack_any, id_adv;

    // In S_DROP the squashed request's address must stay on the bus while pc moves on.
    assign imem.imem_req  = (state_q != S_IDLE);
    assign imem.imem_addr = (state_q == S_DROP) ? addr_q : pc_q;

    always_comb begin
        ack_live      = imem.imem_ack && (state_q == S_REQ);
        ack_any       = imem.imem_ack && (state_q != S_IDLE);
        id_adv        = !stall || !id_valid_q;

        state_d       = state_q;
        pc_d          = pc_q;
        addr_d        = imem.imem_addr;
        id_valid_d    = id_valid_q;
        id_inst_d     = id_inst_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        misalign_d    = redirect_valid && (redirect_pc[1:0] != 2'b00);
        skid_push     = 1'b0;
        skid_pop      = 1'b0;
        skid_flush    = 1'b0;

        if (redirect_valid) begin
            skid_flush = 1'b1;
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
            pc_d       = align_pc(redirect_pc);
            case (state_q)
                S_IDLE:  state_d = S_REQ;
                default: state_d = ack_any ? S_REQ : S_DROP;
            endcase
        end else begin
            if (id_adv) begin
                if (skid_vld) begin
                    skid_pop      = 1'b1;
                    id_valid_d    = 1'b1;
                    id_inst_d     = skid_inst;
                    id_pc_d       = skid_pc;
                    id_pc_plus4_d = skid_pc + 32'd4;
                end else if (ack_live) begin
                    id_valid_d    = 1'b1;
                    id_inst_d     = imem.imem_rdata;
                    id_pc_d       = pc_q;
                    id_pc_plus4_d = pc_q + 32'd4;
                end else begin
                    id_valid_d = 1'b0;
                    id_inst_d  = NOP_INST;
                end
            end else if (ack_live) begin
                skid_push = 1'b1;
            end

            if (ack_live) begin
                pc_d = pc_q + 32'd4;
            end

            // Skid is always empty in S_REQ, so a push means it is full next cycle.
            case (state_q)
                S_IDLE:  if (!skid_vld) state_d = S_REQ;
                S_REQ:   if (skid_push) state_d = S_IDLE;
                S_DROP:  if (ack_any)   state_d = S_REQ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            addr_q        <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_inst_q     <= NOP_INST;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            addr_q        <= addr_d;
            id_valid_q    <= id_valid_d;
            id_inst_q     <= id_inst_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            misalign_q    <= misalign_d;
        end
    end

    if_skid_buffer u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (skid_push),
        .push_inst (imem.imem_rdata),
        .push_pc   (pc_q),
        .pop       (skid_pop),
        .flush     (skid_flush),
        .vld       (skid_vld),
        .inst      (skid_inst),
        .pc        (skid_pc)
    );

    assign id_valid       = id_valid_q;
    assign id_inst        = id_inst_q;
    assign id_pc          = id_pc_q;
    assign id_pc_plus4    = id_pc_plus4_q;
    assign fetch_misalign = misalign_q;

endmodule
